// File: rtl/segled_capture.sv
// segled_capture: samples a scanned six-digit 7-segment bus, recovers each
// digit value and decimal-point level, and publishes all six together as one
// coherent frame. Also flags undecodable patterns, illegal enables and loss
// of the scan.
module segled_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic [5:0] SEG_EN,
  input  logic [7:0] SEG_DATA,
  input  logic       CLR_ERR,
  output logic [3:0] hours2_data,
  output logic [3:0] hours1_data,
  output logic [3:0] minutes2_data,
  output logic [3:0] minutes1_data,
  output logic [3:0] seconds2_data,
  output logic [3:0] seconds1_data,
  output logic [5:0] dp_flags,
  output logic       frame_done,
  output logic       frame_valid,
  output logic       pat_err,
  output logic       en_err,
  output logic       scan_lost
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // state is kept as a named enum so checkers can observe it directly
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
  state_t state;

  logic [5:0]      smp_en, prv_en;
  logic [7:0]      smp_data, prv_data;
  logic [7:0]      cnt;
  logic [TW-1:0]   timer;
  logic [5:0]      seen, seen_next;
  logic [5:0][3:0] shadow;
  logic [5:0]      shadow_dp;
  logic [5:0][3:0] disp;

  logic [5:0] low;
  logic       changed, blank, one_low;
  logic [4:0] dec;
  logic       commit, commit_ok, commit_pat, commit_en, publish, tmo_hit;

  // {valid, value}; the decimal point is not part of the pattern
  function automatic logic [4:0] decode7(input logic [6:0] s);
    case (s)
      7'h3F: return {1'b1, 4'h0};
      7'h06: return {1'b1, 4'h1};
      7'h5B: return {1'b1, 4'h2};
      7'h4F: return {1'b1, 4'h3};
      7'h66: return {1'b1, 4'h4};
      7'h6D: return {1'b1, 4'h5};
      7'h7D: return {1'b1, 4'h6};
      7'h07: return {1'b1, 4'h7};
      7'h7F: return {1'b1, 4'h8};
      7'h6F: return {1'b1, 4'h9};
      7'h77: return {1'b1, 4'hA};
      7'h7C: return {1'b1, 4'hB};
      7'h58: return {1'b1, 4'hC};
      7'h5E: return {1'b1, 4'hD};
      7'h79: return {1'b1, 4'hE};
      7'h71: return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  assign low     = ~smp_en;
  assign changed = {smp_en, smp_data} != {prv_en, prv_data};
  assign blank   = (low == 6'b0);
  assign one_low = $onehot(low);
  assign dec     = decode7(smp_data[6:0]);

  // commit fires on the cycle the sample has been seen STABLE_CYCLES times
  assign commit     = (state == S_SETTLE) && !changed && (cnt == 8'(STABLE_CYCLES - 1));
  assign commit_ok  = commit && one_low && dec[4];
  assign commit_pat = commit && one_low && !dec[4];
  assign commit_en  = commit && !blank && !one_low;
  assign publish    = (seen == 6'h3F);
  // a successful commit in the same cycle keeps the scan alive
  assign tmo_hit    = !commit_ok && (timer == TW'(TIMEOUT_CYCLES - 1));

  // next seen mask: cleared by publish or timeout, then the new digit is added
  always_comb begin
    seen_next = seen;
    if (publish || tmo_hit) seen_next = 6'b0;
    if (commit_ok) seen_next = seen_next | low;
  end

  // input stage: one register for the live sample, one for change detection
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      smp_en   <= 6'h3F;
      smp_data <= 8'h00;
      prv_en   <= 6'h3F;
      prv_data <= 8'h00;
    end else begin
      smp_en   <= SEG_EN;
      smp_data <= SEG_DATA;
      prv_en   <= smp_en;
      prv_data <= smp_data;
    end
  end

  // settle FSM: count identical samples, commit once, then wait for a change
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (changed) begin
            state <= S_SETTLE;
            cnt   <= 8'd1;
          end
        end
        S_SETTLE: begin
          if (changed) cnt <= 8'd1;
          else if (commit) state <= S_HOLD;
          else cnt <= cnt + 8'd1;
        end
        S_HOLD: begin
          if (changed) begin
            state <= blank ? S_IDLE : S_SETTLE;
            cnt   <= 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // shadow capture, frame publish, scan timeout and sticky error flags
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      seen        <= 6'b0;
      shadow      <= '0;
      shadow_dp   <= 6'b0;
      disp        <= '0;
      dp_flags    <= 6'b0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      timer       <= '0;
      scan_lost   <= 1'b0;
      pat_err     <= 1'b0;
      en_err      <= 1'b0;
    end else begin
      frame_done <= publish;
      seen       <= seen_next;
      if (commit_ok) begin
        for (int i = 0; i < 6; i++) begin
          if (low[i]) begin
            shadow[i]    <= dec[3:0];
            shadow_dp[i] <= smp_data[7];
          end
        end
      end
      if (publish) begin
        disp        <= shadow;
        dp_flags    <= shadow_dp;
        frame_valid <= 1'b1;
      end
      if (commit_ok) begin
        timer     <= '0;
        scan_lost <= 1'b0;
      end else if (timer != TW'(TIMEOUT_CYCLES)) begin
        timer <= timer + 1'b1;
      end
      if (tmo_hit) begin
        scan_lost   <= 1'b1;
        frame_valid <= 1'b0;
      end
      pat_err <= (pat_err & ~CLR_ERR) | commit_pat;
      en_err  <= (en_err & ~CLR_ERR) | commit_en;
    end
  end

  assign hours2_data   = disp[0];
  assign hours1_data   = disp[1];
  assign minutes2_data = disp[2];
  assign minutes1_data = disp[3];
  assign seconds2_data = disp[4];
  assign seconds1_data = disp[5];

endmodule
